// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_pkg
// Shared encodings for the two-master memory/IO bus arbiter:
//   - requester command encodings (MNONE / MREAD / MWRITE; 2'b11 acts as NONE)
//   - ownership FSM state encoding (IDLE / OWN0 / OWN1)
//   - default IO-space register addresses (LED write-only, switch read-only)
// ---------------------------------------------------------------------------
package mem_bus_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  // Only READ and WRITE request the bus; the spare encoding 2'b11 is idle.
  function automatic logic cmd_active(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles both requester ports and the RAM-side signals of the arbiter.
//   cmdX/addrX/wdataX   : requester X command, address, write data
//   gntX/rdataX/rvalidX : ownership grant, read data, read-data valid
//   ram_addr/ram_write/ram_din : RAM word address, write enable, write data
//   ram_dout            : RAM read data, valid one cycle after ram_addr
// Modports:
//   slave  - the arbiter
//   master - the environment (requesters plus the RAM)
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);

  logic [1:0]    cmd0,   cmd1;
  logic [AW-1:0] addr0,  addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0,   gnt1;
  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1;

  logic [7:0]    ram_addr;
  logic          ram_write;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  cmd0, addr0, wdata0, cmd1, addr1, wdata1, ram_dout,
    output gnt0, rdata0, rvalid0, gnt1, rdata1, rvalid1,
           ram_addr, ram_write, ram_din
  );

  modport master (
    output cmd0, addr0, wdata0, cmd1, addr1, wdata1, ram_dout,
    input  gnt0, rdata0, rvalid0, gnt1, rdata1, rvalid1,
           ram_addr, ram_write, ram_din
  );

endinterface

// File: rtl/mem_bus_arbiter_io_regs.sv
// ---------------------------------------------------------------------------
// mem_io_regs
// IO-space decode for the arbiter: the write-only LED register and the
// read-only switch port.
//   clk, reset  : clock, synchronous active-high reset
//   issue_i     : an access is being issued by the current owner this cycle
//   is_write_i  : the issued access is a WRITE
//   addr_i      : owner address (MSB set selects IO space)
//   wdata_i     : low byte of the owner's write data
//   sw_in_i     : switch inputs
//   io_sel_o    : address lies in IO space
//   io_rdata_o  : IO read data for the current address
//   led_o       : LED register
// ---------------------------------------------------------------------------
module mem_io_regs
  import mem_bus_pkg::*;
#(
  parameter int            AW       = 9,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] LED_ADDR = mem_bus_pkg::LED_ADDR,
  parameter logic [AW-1:0] SW_ADDR  = mem_bus_pkg::SW_ADDR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_i,
  input  logic          is_write_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  input  logic [7:0]    sw_in_i,
  output logic          io_sel_o,
  output logic [DW-1:0] io_rdata_o,
  output logic [7:0]    led_o
);

  logic [7:0] led_q;

  assign io_sel_o = addr_i[AW-1];

  // Only the switch address returns data; every other IO read yields zero.
  assign io_rdata_o = (addr_i == SW_ADDR) ? {{(DW-8){1'b0}}, sw_in_i} : '0;

  // Writes to IO addresses other than the LED register are silently dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
    end else if (issue_i && is_write_i && (addr_i == LED_ADDR)) begin
      led_q <= wdata_i;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-port 256-word RAM plus memory-mapped IO (LEDs, switches)
// between two requesters. Port 0 is the CPU, port 1 a secondary master.
// A round-robin ownership FSM grants the bus; the owner issues one access per
// cycle while its command is active; read data returns with 1-cycle latency.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_bus_arbiter_if.slave (both requesters and the RAM port)
//   sw_in      : switch inputs (readable at SW_ADDR)
//   led_out    : LED register (writable at LED_ADDR)
// Optional build macro MEM_ARB_BURST_LIMIT_EN: force an ownership hand-over
// after BURST_MAX accesses when the other port is waiting.
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int            AW        = 9,
  parameter int            DW        = 16,
`ifdef MEM_ARB_BURST_LIMIT_EN
  parameter int            BURST_MAX = 8,
`endif
  parameter logic [AW-1:0] LED_ADDR  = mem_bus_pkg::LED_ADDR,
  parameter logic [AW-1:0] SW_ADDR   = mem_bus_pkg::SW_ADDR
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_bus_arbiter_if.slave        bus,
  input  logic [7:0]              sw_in,
  output logic [7:0]              led_out
);

  state_e        state_q;
  logic          last_owner_q;   // 0: port 0 owned last, 1: port 1 owned last
`ifdef MEM_ARB_BURST_LIMIT_EN
  logic [3:0]    cnt_q;
  logic          burst_done;
`endif

  logic          act0, act1;
  logic          own1;
  logic [1:0]    own_cmd;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;
  logic          issue, is_read, is_write;
  logic          io_sel;
  logic [DW-1:0] io_rdata;

  logic          rd_pend_q, rd_port_q, io_sel_q;
  logic [DW-1:0] io_data_q, rdata0_q, rdata1_q;
  logic [DW-1:0] rd_result;
  logic          rvalid0, rvalid1;

  assign act0 = cmd_active(bus.cmd0);
  assign act1 = cmd_active(bus.cmd1);

  // The owner's inputs drive the shared bus; the non-owner is ignored.
  assign own1      = (state_q == OWN1);
  assign own_cmd   = own1 ? bus.cmd1   : bus.cmd0;
  assign own_addr  = own1 ? bus.addr1  : bus.addr0;
  assign own_wdata = own1 ? bus.wdata1 : bus.wdata0;

  // NOTE: reset gates the issue strobe so a write presented in the reset cycle
  // never reaches the RAM or the LED register.
  assign issue    = (state_q != IDLE) && cmd_active(own_cmd) && !reset;
  assign is_read  = (own_cmd == MREAD);
  assign is_write = (own_cmd == MWRITE);

  assign bus.ram_write = issue && is_write && !own_addr[AW-1];
  assign bus.ram_addr  = issue ? own_addr[7:0] : '0;
  assign bus.ram_din   = issue ? own_wdata     : '0;

  assign bus.gnt0 = (state_q == OWN0);
  assign bus.gnt1 = (state_q == OWN1);

`ifdef MEM_ARB_BURST_LIMIT_EN
  // True when the access issued this cycle is the BURST_MAX-th (or later).
  assign burst_done = ({1'b0, cnt_q} + 5'd1) >= 5'(BURST_MAX);
`endif

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
`ifdef MEM_ARB_BURST_LIMIT_EN
      cnt_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef MEM_ARB_BURST_LIMIT_EN
          cnt_q <= '0;
`endif
          if (act0 && act1) state_q <= last_owner_q ? OWN0 : OWN1;
          else if (act0)    state_q <= OWN0;
          else if (act1)    state_q <= OWN1;
        end
        OWN0: begin
          if (!act0) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b0;
`ifdef MEM_ARB_BURST_LIMIT_EN
          end else if (burst_done && act1) begin
            state_q      <= OWN1;
            last_owner_q <= 1'b0;
            cnt_q        <= '0;
          end else if (cnt_q != 4'hF) begin
            cnt_q <= cnt_q + 4'd1;
`endif
          end
        end
        OWN1: begin
          if (!act1) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
`ifdef MEM_ARB_BURST_LIMIT_EN
          end else if (burst_done && act0) begin
            state_q      <= OWN0;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
          end else if (cnt_q != 4'hF) begin
            cnt_q <= cnt_q + 4'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_io_regs #(
    .AW       (AW),
    .DW       (DW),
    .LED_ADDR (LED_ADDR),
    .SW_ADDR  (SW_ADDR)
  ) u_io_regs (
    .clk        (clk),
    .reset      (reset),
    .issue_i    (issue),
    .is_write_i (is_write),
    .addr_i     (own_addr),
    .wdata_i    (own_wdata[7:0]),
    .sw_in_i    (sw_in),
    .io_sel_o   (io_sel),
    .io_rdata_o (io_rdata),
    .led_o      (led_out)
  );

  // Read return: the issue edge records which port asked and whether the
  // data comes from IO (captured now) or the RAM (arriving next cycle).
  assign rd_result = io_sel_q ? io_data_q : bus.ram_dout;
  assign rvalid0   = rd_pend_q && !rd_port_q && !reset;
  assign rvalid1   = rd_pend_q &&  rd_port_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
      io_sel_q  <= 1'b0;
      io_data_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rd_pend_q <= issue && is_read;
      if (issue && is_read) begin
        rd_port_q <= own1;
        io_sel_q  <= io_sel;
        io_data_q <= io_rdata;
      end
      if (rvalid0) rdata0_q <= rd_result;
      if (rvalid1) rdata1_q <= rd_result;
    end
  end

  // Each port's read data holds its last delivered value between returns.
  assign bus.rvalid0 = rvalid0;
  assign bus.rvalid1 = rvalid1;
  assign bus.rdata0  = rvalid0 ? rd_result : rdata0_q;
  assign bus.rdata1  = rvalid1 ? rd_result : rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter: a behavioural registered-read RAM,
// a linear sequence of stimulus steps, and immediate assertions against
// hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw_in;
  logic [7:0] led_out;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [256];

  mem_bus_arbiter_if #(.AW(9), .DW(16)) bus ();

  mem_bus_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .sw_in   (sw_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read (read-before-write).
  always @(posedge clk) begin
    bus.ram_dout <= mem[bus.ram_addr];
    if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_din;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int g1;

    for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    mem[8'h05] <= 16'hABCD;
    mem[8'h10] <= 16'h1010;
    mem[8'h11] <= 16'h2121;
    mem[8'h12] <= 16'h3232;

    reset      = 1'b1;
    sw_in      = 8'h00;
    bus.cmd0   = MNONE;
    bus.addr0  = '0;
    bus.wdata0 = '0;
    bus.cmd1   = MNONE;
    bus.addr1  = '0;
    bus.wdata1 = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_gnt0",      16'(bus.gnt0),      16'd0);
    check("rst_gnt1",      16'(bus.gnt1),      16'd0);
    check("rst_rvalid0",   16'(bus.rvalid0),   16'd0);
    check("rst_rvalid1",   16'(bus.rvalid1),   16'd0);
    check("rst_ram_write", 16'(bus.ram_write), 16'd0);
    check("rst_ram_addr",  16'(bus.ram_addr),  16'd0);
    check("rst_ram_din",   bus.ram_din,        16'd0);
    check("rst_led",       16'(led_out),       16'd0);

    // Single read by port 0 of RAM[5]
    bus.cmd0  = MREAD;
    bus.addr0 = 9'h005;
    #1;
    check("rd_idle_gnt0", 16'(bus.gnt0), 16'd0);
    tick();
    check("rd_gnt0",     16'(bus.gnt0),     16'd1);
    check("rd_gnt1",     16'(bus.gnt1),     16'd0);
    check("rd_ram_addr", 16'(bus.ram_addr), 16'h0005);
    tick();
    bus.cmd0 = MNONE;
    #1;
    check("rd_rvalid0", 16'(bus.rvalid0), 16'd1);
    check("rd_rdata0",  bus.rdata0,       16'hABCD);
    check("rd_gnt1_b",  16'(bus.gnt1),    16'd0);
    tick();
    check("rd_done_rvalid0", 16'(bus.rvalid0), 16'd0);
    check("rd_done_gnt0",    16'(bus.gnt0),    16'd0);
    check("rd_hold_rdata0",  bus.rdata0,       16'hABCD);

    // Simultaneous writes after reset: port 0 first, then port 1
    do_reset();
    bus.cmd0 = MWRITE; bus.addr0 = 9'h020; bus.wdata0 = 16'h1111;
    bus.cmd1 = MWRITE; bus.addr1 = 9'h021; bus.wdata1 = 16'h2222;
    tick();
    check("tie_gnt0",      16'(bus.gnt0),      16'd1);
    check("tie_gnt1",      16'(bus.gnt1),      16'd0);
    check("tie_ram_write", 16'(bus.ram_write), 16'd1);
    check("tie_ram_addr",  16'(bus.ram_addr),  16'h0020);
    check("tie_ram_din",   bus.ram_din,        16'h1111);
    tick();
    bus.cmd0 = MNONE;
    tick();
    check("tie_idle_gnt0", 16'(bus.gnt0), 16'd0);
    check("tie_idle_gnt1", 16'(bus.gnt1), 16'd0);
    tick();
    check("tie_own1_gnt1",     16'(bus.gnt1),      16'd1);
    check("tie_own1_ram_addr", 16'(bus.ram_addr),  16'h0021);
    check("tie_own1_ram_din",  bus.ram_din,        16'h2222);
    tick();
    bus.cmd1 = MNONE;
    check("tie_mem20", mem[8'h20], 16'h1111);
    check("tie_mem21", mem[8'h21], 16'h2222);
    tick();
    check("tie_rel_gnt1", 16'(bus.gnt1), 16'd0);
    bus.cmd0 = MWRITE; bus.addr0 = 9'h022;
    bus.cmd1 = MWRITE;
    tick();
    check("tie2_gnt0", 16'(bus.gnt0), 16'd1);
    check("tie2_gnt1", 16'(bus.gnt1), 16'd0);
    bus.cmd0 = MNONE;
    bus.cmd1 = MNONE;
    tick();

    // Port 1 IO accesses
    bus.cmd1 = MWRITE; bus.addr1 = 9'h100; bus.wdata1 = 16'h005A;
    tick();
    check("io_gnt1",       16'(bus.gnt1),      16'd1);
    check("io_ram_write",  16'(bus.ram_write), 16'd0);
    tick();
    check("io_led",        16'(led_out),       16'h005A);
    bus.addr1 = 9'h120; bus.wdata1 = 16'h00FF;
    #1;
    check("io_drop_ram_write", 16'(bus.ram_write), 16'd0);
    tick();
    check("io_drop_led", 16'(led_out), 16'h005A);
    bus.cmd1 = MREAD; bus.addr1 = 9'h140; sw_in = 8'h3C;
    tick();
    bus.cmd1 = MNONE; sw_in = 8'h99;
    #1;
    check("io_sw_rvalid1", 16'(bus.rvalid1), 16'd1);
    check("io_sw_rdata1",  bus.rdata1,       16'h003C);
    check("io_sw_rvalid0", 16'(bus.rvalid0), 16'd0);
    tick();
    check("io_done_rvalid1", 16'(bus.rvalid1), 16'd0);
    check("io_hold_rdata1",  bus.rdata1,       16'h003C);
    check("io_done_gnt1",    16'(bus.gnt1),    16'd0);

    // Back-to-back reads by port 0, then release with cmd 2'b11
    bus.cmd0 = MREAD; bus.addr0 = 9'h010;
    tick();
    tick();
    bus.addr0 = 9'h011;
    #1;
    check("b2b_rvalid0_a", 16'(bus.rvalid0), 16'd1);
    check("b2b_rdata0_a",  bus.rdata0,       16'h1010);
    tick();
    bus.addr0 = 9'h012;
    #1;
    check("b2b_rvalid0_b", 16'(bus.rvalid0), 16'd1);
    check("b2b_rdata0_b",  bus.rdata0,       16'h2121);
    tick();
    bus.cmd0 = 2'b11;
    #1;
    check("b2b_rvalid0_c", 16'(bus.rvalid0), 16'd1);
    check("b2b_rdata0_c",  bus.rdata0,       16'h3232);
    check("b2b_gnt0_c",    16'(bus.gnt0),    16'd1);
    tick();
    check("b2b_rel_gnt0",    16'(bus.gnt0),    16'd0);
    check("b2b_rel_rvalid0", 16'(bus.rvalid0), 16'd0);
    bus.cmd0 = MNONE;

    // Reset in the cycle after a read issue
    bus.cmd0 = MREAD; bus.addr0 = 9'h005;
    tick();
    tick();
    reset    = 1'b1;
    bus.cmd0 = MNONE;
    #1;
    check("rstmid_rvalid0_in", 16'(bus.rvalid0), 16'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rstmid_rvalid0", 16'(bus.rvalid0), 16'd0);
    check("rstmid_led",     16'(led_out),     16'd0);
    check("rstmid_gnt0",    16'(bus.gnt0),    16'd0);

    // Port 0 streaming reads while port 1 waits
    bus.cmd0 = MREAD; bus.addr0 = 9'h010;
    bus.cmd1 = MREAD; bus.addr1 = 9'h011;
    tick();
    check("burst_gnt0_start", 16'(bus.gnt0), 16'd1);
`ifdef MEM_ARB_BURST_LIMIT_EN
    n = 0;
    while (bus.gnt0 && n < 30) begin
      n++;
      tick();
    end
    check("burst_len",  16'(n),         16'd8);
    check("burst_gnt1", 16'(bus.gnt1),  16'd1);
`else
    n  = 0;
    g1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.gnt0) n++;
      if (bus.gnt1) g1++;
      tick();
    end
    check("hold_gnt0_cycles", 16'(n),  16'd20);
    check("hold_gnt1_cycles", 16'(g1), 16'd0);
`endif
    bus.cmd0 = MNONE;
    bus.cmd1 = MNONE;
    tick();
    tick();
    check("end_gnt0", 16'(bus.gnt0), 16'd0);
    check("end_gnt1", 16'(bus.gnt1), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
